ternary_matvec: RTL and testbench

Streaming ternary matrix-vector multiplier that consumes the packed 2-bit weight bus produced by the weight loader and applies it to a serial stream of signed activations. It accumulates one activation per accepted input beat into all output lanes in parallel. It then drains the lane results one per beat through a valid/ready port. It sits directly downstream of the weight loader and upstream of the output serializer in the tiny-ternary datapath.

---
 rtl/ternary_matvec.sv | 137 +++++++++++++
 tb/tb_ternary_matvec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_matvec.sv
// ternary_matvec
//   Streaming ternary matrix-vector multiplier. Each accepted activation beat
//   is multiplied by one row of 2-bit ternary weights. The products are
//   accumulated into all output lanes in parallel. The lane sums are then
//   drained one per beat over a valid/ready port.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   ena                block enable (low: every register holds)
//   weights            packed ternary weights; row i, lane j at
//                      base=2*(i*MAX_OUT_LEN+j), msb=bit base, lsb=bit base+1
//   cfg_in_len         activations per vector minus 1 (latched on start)
//   cfg_out_len        lanes to drain minus 1 (latched on start)
//   start              begin a vector (IDLE only)
//   in_valid/in_data   signed activation stream, in_ready high in ACCUM
//   out_valid/out_data/out_idx/out_ready  lane result stream
//   busy               high in ACCUM and DRAIN
//   done               one-cycle pulse after the final lane handshake
module ternary_matvec #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = DATA_W + $clog2(MAX_IN_LEN) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights,
  input  logic [$clog2(MAX_IN_LEN)-1:0]     cfg_in_len,
  input  logic [$clog2(MAX_OUT_LEN)-1:0]    cfg_out_len,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic signed [DATA_W-1:0]          in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic signed [ACC_W-1:0]           out_data,
  output logic [$clog2(MAX_OUT_LEN)-1:0]    out_idx,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int IN_W  = $clog2(MAX_IN_LEN);
  localparam int OUT_W = $clog2(MAX_OUT_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [IN_W-1:0]          row;
  logic [OUT_W-1:0]         lane;
  logic [IN_W-1:0]          in_len_q;
  logic [OUT_W-1:0]         out_len_q;
  logic signed [ACC_W-1:0]  acc [MAX_OUT_LEN];
  logic [1:0]               w_dec [MAX_IN_LEN][MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  x_ext;
  logic                     accept_in, accept_out, last_in, last_out;

  // Ternary multiply-accumulate: 01 adds, 11 subtracts, 00 and the
  // reserved 10 leave the accumulator unchanged.
  function automatic logic signed [ACC_W-1:0] tern_mac(
    input logic signed [ACC_W-1:0] a,
    input logic [1:0]              w,
    input logic signed [ACC_W-1:0] x
  );
    case (w)
      2'b01:   tern_mac = a + x;
      2'b11:   tern_mac = a - x;
      default: tern_mac = a;
    endcase
  endfunction

  // The loader packs msb at the lower bit of each pair, so the pair is
  // swapped here to get {msb,lsb}.
  for (genvar gi = 0; gi < MAX_IN_LEN; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_OUT_LEN; gj++) begin : g_lane
      assign w_dec[gi][gj] = {weights[2*(gi*MAX_OUT_LEN+gj)],
                              weights[2*(gi*MAX_OUT_LEN+gj)+1]};
    end
  end

  assign x_ext      = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign accept_in  = (state == ACCUM) && in_valid && ena;
  assign accept_out = (state == DRAIN) && out_ready && ena;
  assign last_in    = accept_in && (row == in_len_q);
  assign last_out   = accept_out && (lane == out_len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && ena) state_nxt = ACCUM;
      ACCUM:   if (last_in)      state_nxt = DRAIN;
      DRAIN:   if (last_out)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Accumulate stage: counters, latched config and lane accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      lane      <= '0;
      in_len_q  <= '0;
      out_len_q <= '0;
      done      <= 1'b0;
      for (int j = 0; j < MAX_OUT_LEN; j++) acc[j] <= '0;
    end else if (ena) begin
      done <= last_out;
      if (state == IDLE && start) begin
        in_len_q  <= cfg_in_len;
        out_len_q <= cfg_out_len;
        row       <= '0;
        lane      <= '0;
        for (int j = 0; j < MAX_OUT_LEN; j++) acc[j] <= '0;
      end
      if (accept_in) begin
        for (int j = 0; j < MAX_OUT_LEN; j++)
          acc[j] <= tern_mac(acc[j], w_dec[row][j], x_ext);
        row <= row + 1'b1;
        if (last_in) lane <= '0;
      end
      if (accept_out) lane <= lane + 1'b1;
    end
  end

  // Drain stage: lane result presented straight from the accumulators
  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = acc[lane];
  assign out_idx   = lane;

endmodule

// File: tb/tb_ternary_matvec.sv
module tb_ternary_matvec;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic [255:0]       weights;
  logic [3:0]         cfg_in_len;
  logic [2:0]         cfg_out_len;
  logic               start;
  logic               in_valid;
  logic signed [7:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [12:0] out_data;
  logic [2:0]         out_idx;
  logic               out_ready;
  logic               busy;
  logic               done;

  int tests = 0;
  int fails = 0;

  ternary_matvec dut (
    .clk(clk), .rst(rst), .ena(ena), .weights(weights),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0]      w;
    logic [3:0]        il;
    logic [2:0]        ol;
    logic [15:0][7:0]  din;
    logic [7:0][12:0]  ex;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] w, input int i,
                                       input int j, input logic [1:0] c);
    logic [255:0] r;
    r = w;
    r[2*(i*8+j)]   = c[1];
    r[2*(i*8+j)+1] = c[0];
    return r;
  endfunction

  function automatic logic [255:0] fill(input logic [1:0] c);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++) r = put(r, i, j, c);
    return r;
  endfunction

  // Runs one vector from IDLE at a negedge; returns at the negedge where done is high.
  task automatic run_vec(input int k, input bit stall, input bit poke_start, input bit ena_gap);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    weights     = tbl[k].w;
    cfg_in_len  = tbl[k].il;
    cfg_out_len = tbl[k].ol;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done_low", done, 0);
    // config changes after start must not affect the running vector
    cfg_in_len  = 4'd0;
    cfg_out_len = 3'd0;
    for (int r = 0; r <= int'(tbl[k].il); r++) begin
      if (stall)
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      if (ena_gap && r == 1) begin
        ena = 1'b0; in_valid = 1'b1; in_data = 8'sd99;
        repeat (2) @(negedge clk);
        chk("ena_low_in_ready", in_ready, 1);
        ena = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = $signed(tbl[k].din[r]);
      start    = poke_start && (r == 2);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("drain_in_ready", in_ready, 0);
    for (int l = 0; l <= int'(tbl[k].ol); l++) begin
      if (stall && $urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_data", out_data, $signed(tbl[k].ex[l]));
        chk("stall_idx", out_idx, l);
      end
      if (ena_gap && l == 2) begin
        ena = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ena_low_idx", out_idx, 2);
        ena = 1'b1;
      end
      out_ready = 1'b1;
      start     = poke_start && (l == 0) && (tbl[k].ol != 3'd0);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, $signed(tbl[k].ex[l]));
      chk("out_idx", out_idx, l);
      @(negedge clk);
      start = 1'b0;
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_valid", out_valid, 0);
    if (ena_gap) begin
      ena = 1'b0;
      @(negedge clk);
      chk("done_hold_ena_low", done, 1);
      ena = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // V0: all +1, inputs 1..4 -> 10 in every lane
    tbl[0] = '0;
    tbl[0].w = fill(2'b01); tbl[0].il = 4'd3; tbl[0].ol = 3'd7;
    for (int r = 0; r < 4; r++) tbl[0].din[r] = 8'(r + 1);
    for (int l = 0; l < 8; l++) tbl[0].ex[l] = 13'sd10;
    // V1: alternating +1/-1 by row, lane 7 reserved code 10
    tbl[1] = '0;
    tbl[1].il = 4'd1; tbl[1].ol = 3'd7;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++)
        tbl[1].w = put(tbl[1].w, i, j, (j == 7) ? 2'b10 : (((i + j) % 2 == 0) ? 2'b01 : 2'b11));
    tbl[1].din[0] = 8'sd5; tbl[1].din[1] = -8'sd3;
    for (int l = 0; l < 7; l++) tbl[1].ex[l] = (l % 2 == 0) ? 13'sd8 : -13'sd8;
    tbl[1].ex[7] = 13'sd0;
    // V2: full-scale -1 * -128 over 16 rows -> +2048, three lanes drained
    tbl[2] = '0;
    tbl[2].w = fill(2'b11); tbl[2].il = 4'd15; tbl[2].ol = 3'd2;
    for (int r = 0; r < 16; r++) tbl[2].din[r] = 8'h80;
    for (int l = 0; l < 3; l++) tbl[2].ex[l] = 13'sd2048;
    // V3: full-scale +1 * -128 -> -2048, one lane
    tbl[3] = '0;
    tbl[3].w = fill(2'b01); tbl[3].il = 4'd15; tbl[3].ol = 3'd0;
    for (int r = 0; r < 16; r++) tbl[3].din[r] = 8'h80;
    tbl[3].ex[0] = -13'sd2048;
    // V4: single activation 7 against +1, -1, 0, reserved
    tbl[4] = '0;
    tbl[4].w = fill(2'b01);
    tbl[4].w = put(tbl[4].w, 0, 1, 2'b11);
    tbl[4].w = put(tbl[4].w, 0, 2, 2'b00);
    tbl[4].w = put(tbl[4].w, 0, 3, 2'b10);
    tbl[4].il = 4'd0; tbl[4].ol = 3'd3;
    tbl[4].din[0] = 8'sd7;
    tbl[4].ex[0] = 13'sd7; tbl[4].ex[1] = -13'sd7; tbl[4].ex[2] = 13'sd0; tbl[4].ex[3] = 13'sd0;

    rst = 1'b1; ena = 1'b1; weights = '0; cfg_in_len = '0; cfg_out_len = '0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back vectors at full throughput
    for (int k = 0; k < 5; k++) run_vec(k, 1'b0, 1'b0, 1'b0);

    // Backpressure on both ports
    run_vec(0, 1'b1, 1'b0, 1'b0);
    run_vec(1, 1'b1, 1'b0, 1'b0);
    // start poked mid-ACCUM and mid-DRAIN
    run_vec(2, 1'b0, 1'b1, 1'b0);
    // ena low during ACCUM, DRAIN and after done
    run_vec(0, 1'b0, 1'b0, 1'b1);

    // Reset mid-ACCUM
    weights = tbl[2].w; cfg_in_len = tbl[2].il; cfg_out_len = tbl[2].ol;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1; in_data = -8'sd128;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("amid_rst_busy", busy, 0);
    chk("amid_rst_in_ready", in_ready, 0);
    chk("amid_rst_out_valid", out_valid, 0);
    chk("amid_rst_out_data", out_data, 0);
    chk("amid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    run_vec(4, 1'b0, 1'b0, 1'b0);
    run_vec(3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_done_cleared", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
